// File: rtl/etc_rom_arbiter_pkg.sv
// Shared ETC2 decoder definitions used by the ROM arbiter: default ROM geometry,
// arbiter FSM encoding and a saturating counter helper.
package etc_rom_arbiter_pkg;

    localparam int ETC_ADDR_W = 10;   // 1024 ETC2 blocks
    localparam int ETC_DATA_W = 64;   // one ETC2 block per ROM word

    localparam int GCNT_W = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_e;

    // Requester index as stored in the last-granted pointer.
    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

    function automatic logic [GCNT_W-1:0] sat_inc16(input logic [GCNT_W-1:0] cnt,
                                                    input logic            inc);
        logic [GCNT_W-1:0] res;
        res = cnt;
        if (inc && (cnt != {GCNT_W{1'b1}})) begin
            res = cnt + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/etc_rom_arbiter_if.sv
// Requester and ROM-side signal bundle of the ETC2 ROM arbiter.
interface etc_rom_arbiter_if #(
    parameter int ADDR_W = etc_rom_arbiter_pkg::ETC_ADDR_W,
    parameter int DATA_W = etc_rom_arbiter_pkg::ETC_DATA_W
);

    // Handshake: reqN is held (with addrN stable) until gntN is seen high in the
    // same cycle; a grant is the transfer. rvalidN then marks rdata for exactly
    // one cycle, one cycle after gntN. The ROM answers rom_en/rom_addr with
    // rom_dout one cycle later.
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;

    modport slave (
        input  req0, req1, addr0, addr1, rom_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, rom_en, rom_addr
    );

    modport master (
        output req0, req1, addr0, addr1, rom_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, rom_en, rom_addr
    );

endinterface

// File: rtl/etc_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, 1-cycle-latency ETC2 ROM.
// Optional grant statistics (gcnt0/gcnt1) are built when ETC_ROM_ARB_STATS_EN is defined.
module etc_rom_arbiter
    import etc_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ETC_ADDR_W,
    parameter int DATA_W = ETC_DATA_W
) (
    input  logic                   sclk,
    input  logic                   rsrt,
    etc_rom_arbiter_if.slave       bus,
    output logic                   busy
`ifdef ETC_ROM_ARB_STATS_EN
   ,output logic [GCNT_W-1:0]      gcnt0,
    output logic [GCNT_W-1:0]      gcnt1
`endif
);

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              gnt0_w, gnt1_w;
    logic [ADDR_W-1:0] rom_addr_w;
    logic [DATA_W-1:0] rdata_w;

    // A tie goes to whoever did not win last; reset blocks every grant.
    always_comb begin
        gnt0_w = 1'b0;
        gnt1_w = 1'b0;
        if (!rsrt) begin
            if (bus.req0 && (!bus.req1 || (last_q == REQ_1))) begin
                gnt0_w = 1'b1;
            end else if (bus.req1) begin
                gnt1_w = 1'b1;
            end
        end
    end

    always_comb begin
        rom_addr_w = '0;
        if (gnt0_w) begin
            rom_addr_w = bus.addr0;
        end else if (gnt1_w) begin
            rom_addr_w = bus.addr1;
        end
    end

    always_comb begin
        last_d    = last_q;
        rvalid0_d = gnt0_w;
        rvalid1_d = gnt1_w;
        if (gnt0_w) begin
            last_d = REQ_0;
        end else if (gnt1_w) begin
            last_d = REQ_1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   state_d = (gnt0_w || gnt1_w) ? ARB_ACTIVE : ARB_IDLE;
            ARB_ACTIVE: state_d = (gnt0_w || gnt1_w) ? ARB_ACTIVE : ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            state_q   <= ARB_IDLE;
            last_q    <= REQ_1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // A read still in flight when reset arrives is dropped, so the registered
    // valids and busy are also masked in the reset cycle itself.
    assign rdata_w     = bus.rom_dout;
    assign bus.rdata   = rdata_w;
    assign bus.gnt0    = gnt0_w;
    assign bus.gnt1    = gnt1_w;
    assign bus.rom_en  = gnt0_w | gnt1_w;
    assign bus.rom_addr = rom_addr_w;
    assign bus.rvalid0 = rvalid0_q & ~rsrt;
    assign bus.rvalid1 = rvalid1_q & ~rsrt;
    assign busy        = (state_q == ARB_ACTIVE) & ~rsrt;

`ifdef ETC_ROM_ARB_STATS_EN
    logic [GCNT_W-1:0] gcnt0_q, gcnt0_d;
    logic [GCNT_W-1:0] gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = sat_inc16(gcnt0_q, gnt0_w);
        gcnt1_d = sat_inc16(gcnt1_q, gnt1_w);
    end

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_etc_rom_arbiter.sv
// Directed bench for etc_rom_arbiter: a ROM model feeds rom_dout, grants push the
// expected read word into exp_q, and a monitor pops it whenever rvalid is seen.
module tb_etc_rom_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int EXP_W  = DATA_W + 1;

  logic sclk;
  logic rsrt;
  logic busy;
`ifdef ETC_ROM_ARB_STATS_EN
  logic [15:0] gcnt0;
  logic [15:0] gcnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  etc_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  etc_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sclk  (sclk),
    .rsrt  (rsrt),
    .bus   (bus.slave),
    .busy  (busy)
`ifdef ETC_ROM_ARB_STATS_EN
   ,.gcnt0 (gcnt0),
    .gcnt1 (gcnt1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- ROM model (1-cycle latency) ----------------
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {16'hE7C2, 6'd0, a, 22'h2A5A5A, ~a};
  endfunction

  initial bus.rom_dout = '0;
  always @(posedge sclk) begin
    if (bus.rom_en) bus.rom_dout <= rom_word(bus.rom_addr);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks one cycle's combinational outputs at the falling edge and queues the
  // read that a grant launches; returns just after the next rising edge.
  task automatic expect_cycle(input logic eg0, input logic eg1,
                              input logic [ADDR_W-1:0] ea, input logic eb);
    @(negedge sclk);
    chk("gnt0",     bus.gnt0,     eg0);
    chk("gnt1",     bus.gnt1,     eg1);
    chk("rom_en",   bus.rom_en,   eg0 | eg1);
    chk("rom_addr", bus.rom_addr, (eg0 | eg1) ? ea : '0);
    chk("busy",     busy,         eb);
    if (eg0) exp_q.push_back({1'b0, rom_word(ea)});
    if (eg1) exp_q.push_back({1'b1, rom_word(ea)});
    @(posedge sclk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [ADDR_W-1:0] a0,
                       input logic r1, input logic [ADDR_W-1:0] a1);
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge sclk) begin
    logic [EXP_W-1:0] e;
    if (bus.rvalid0 || bus.rvalid1) begin
      if (bus.rvalid0 && bus.rvalid1) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_both: got 11 required one-hot at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b required none at %0t",
                 bus.rvalid0, bus.rvalid1, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_id", {63'd0, bus.rvalid1}, {63'd0, e[DATA_W]});
        chk("rdata",     bus.rdata,            e[DATA_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rsrt = 1'b1;
    drive(1'b1, 10'd5, 1'b0, 10'd0);
    @(posedge sclk);
    #1;
    // Reset blocks grants even with a request pending.
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);

    // Single request, granted with no wait; addr1 noise must not leak.
    rsrt = 1'b0;
    drive(1'b1, 10'd5, 1'b0, 10'd9);
    expect_cycle(1'b1, 1'b0, 10'd5, 1'b0);
    drive(1'b0, 10'd5, 1'b0, 10'd9);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b1);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);

    // Fresh reset, then a permanent tie alternates 0,1,0,1.
    rsrt = 1'b1;
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    rsrt = 1'b0;
    drive(1'b1, 10'h010, 1'b1, 10'h020);
    expect_cycle(1'b1, 1'b0, 10'h010, 1'b0);
    expect_cycle(1'b0, 1'b1, 10'h020, 1'b1);
    expect_cycle(1'b1, 1'b0, 10'h010, 1'b1);
    expect_cycle(1'b0, 1'b1, 10'h020, 1'b1);
    drive(1'b0, 10'h010, 1'b0, 10'h020);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b1);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);

    // req1 alone at the top address, then req0 joins at address 0 and wins the tie.
    drive(1'b0, 10'h155, 1'b1, 10'h3FF);
    expect_cycle(1'b0, 1'b1, 10'h3FF, 1'b0);
    expect_cycle(1'b0, 1'b1, 10'h3FF, 1'b1);
    expect_cycle(1'b0, 1'b1, 10'h3FF, 1'b1);
    drive(1'b1, 10'h000, 1'b1, 10'h3FF);
    expect_cycle(1'b1, 1'b0, 10'h000, 1'b1);
    expect_cycle(1'b0, 1'b1, 10'h3FF, 1'b1);
    drive(1'b1, 10'h000, 1'b0, 10'h3FF);
    expect_cycle(1'b1, 1'b0, 10'h000, 1'b1);
    drive(1'b0, 10'h000, 1'b0, 10'h3FF);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b1);

    // Reset right after gnt1: that read is discarded and the next tie goes to 0.
    drive(1'b0, 10'h0AA, 1'b1, 10'd7);
    expect_cycle(1'b0, 1'b1, 10'd7, 1'b0);
    rsrt = 1'b1;
    exp_q.delete();
    drive(1'b1, 10'h0AA, 1'b1, 10'd7);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    rsrt = 1'b0;
    expect_cycle(1'b1, 1'b0, 10'h0AA, 1'b0);
    expect_cycle(1'b0, 1'b1, 10'd7, 1'b1);

    // Idle with live-looking addresses: no enable, address forced to 0.
    drive(1'b0, 10'h2C3, 1'b0, 10'h1F0);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b1);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);

`ifdef ETC_ROM_ARB_STATS_EN
    rsrt = 1'b1;
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    rsrt = 1'b0;
    drive(1'b1, 10'd3, 1'b0, 10'd0);
    for (int i = 0; i < 70000; i++) begin
      @(negedge sclk);
      exp_q.push_back({1'b0, rom_word(10'd3)});
      @(posedge sclk);
      #1;
    end
    drive(1'b0, 10'd3, 1'b0, 10'd0);
    expect_cycle(1'b0, 1'b0, 10'd0, 1'b1);
    @(negedge sclk);
    chk("gcnt0_sat", {48'd0, gcnt0}, 64'd65535);
    chk("gcnt1_zero", {48'd0, gcnt1}, 64'd0);
    @(posedge sclk);
    #1;
    rsrt = 1'b1;
    @(posedge sclk);
    #1;
    @(negedge sclk);
    chk("gcnt0_clr", {48'd0, gcnt0}, 64'd0);
    chk("gcnt1_clr", {48'd0, gcnt1}, 64'd0);
    @(posedge sclk);
    #1;
    rsrt = 1'b0;
`endif

    @(negedge sclk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/etc_rom_arbiter.md
ETC_ROM_ARBITER -- requirements
Module: etc_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM word-address width (1024 blocks).
REQ-002 SHALL have parameter DATA_W, default 64, ROM word width (one ETC2 block).
REQ-003 SHALL have port sclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rsrt  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  read request from requester 0/1, held until granted.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W  word address, stable while reqN high.
REQ-007 SHALL have ports gnt0/gnt1  output  1  grant, combinational, same cycle as reqN.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  read data for requester N is on rdata this cycle.
REQ-009 SHALL have port rdata  output  DATA_W  read data, a pass-through of rom_dout.
REQ-010 SHALL have ports rom_en  output  1, rom_addr  output  ADDR_W, rom_dout  input  DATA_W  to the single-port ROM, which has 1-cycle read latency.
REQ-011 SHALL have port busy  output  1  a read is outstanding (state ACTIVE).

Function
REQ-012 SHALL assert at most one of gnt0/gnt1 per cycle, and only for a requester whose reqN is high.
REQ-013 SHALL, with a single request, grant it in the same cycle with no wait.
REQ-014 SHALL, with both requests high, grant the requester that is not held in the last-granted pointer; last-granted updates to the winner on every grant.
REQ-015 SHALL drive rom_en = gnt0|gnt1 and rom_addr = address of the granted requester; rom_addr SHALL be 0 when there is no grant.
REQ-016 SHALL assert rvalidN exactly one cycle after gntN, for one cycle, via a registered copy of the grant.
REQ-017 SHALL support back-to-back grants every cycle (full throughput), with no bubble between requesters.
REQ-018 SHALL run a 2-state FSM: IDLE->ACTIVE on any grant; ACTIVE->ACTIVE on a grant; ACTIVE->IDLE on no grant; busy = (state==ACTIVE).
REQ-019 SHALL guarantee starvation freedom: a held request is granted within 2 cycles.
REQ-020 SHALL ignore address values of non-requesting ports.

Reset
REQ-021 SHALL, while rsrt is high, force gnt0=gnt1=0 combinationally and rom_en=0.
REQ-022 SHALL, on rsrt, set rvalid0=rvalid1=0, state=IDLE, busy=0, and last-granted=1 (requester 0 wins the first tie).
REQ-023 SHALL, on rsrt during an outstanding read, discard that read: rvalid is not asserted after reset.

Configuration
REQ-024 SHALL, when ETC_ROM_ARB_STATS_EN is defined, add outputs gcnt0/gcnt1 (16 bits each) that count grants per requester. The counters saturate at 16'hFFFF and clear on rsrt.
REQ-025 SHALL, when ETC_ROM_ARB_STATS_EN is undefined, omit gcnt0/gcnt1 and all counter logic; arbitration behaviour is identical.

Structure
REQ-026 SHALL take the FSM state encodings (IDLE=1'b0, ACTIVE=1'b1) and the ADDR_W/DATA_W defaults from the shared ETC2 decoder package.
REQ-027 SHALL be a single module with no sub-modules; the ROM instance stays outside the block.

Verification
REQ-028 SHALL cover: reset, then req0=1 with addr0=5 -> gnt0=1 and rom_addr=5 in the same cycle; rvalid0=1 with rdata=ROM[5] the next cycle.
REQ-029 SHALL cover: after reset, req0 and req1 both held high -> grants alternate 0,1,0,1 on consecutive cycles; rvalid follows each grant by 1 cycle.
REQ-030 SHALL cover: req1 alone for 3 cycles, then req0 joins -> req0 wins the first tie; there is no bubble on rom_en.
REQ-031 SHALL cover: rsrt asserted in the cycle after gnt1 -> rvalid1 stays 0, busy=0, and the next tie goes to requester 0.
REQ-032 SHALL cover: no requests -> rom_en=0, rom_addr=0, busy drops to 0 one cycle after the last grant.
REQ-033 SHALL cover, with ETC_ROM_ARB_STATS_EN defined: 70000 grants to requester 0 -> gcnt0 saturates at 65535, gcnt1 stays 0; rsrt clears both.
